// File: rtl/mshr_pkg.sv
// Shared types and constants for the MSHR queue: FSM states, the
// widest-case entry record and the poison address for empty slots.
package mshr_pkg;

  localparam int ADDR_MAX = 64;
  localparam int DATA_MAX = 64;
  localparam int REG_MAX  = 16;

  localparam logic [ADDR_MAX-1:0] INVALID_ADDR = 64'h0000_0000_DEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic                lw;
    logic                valid;
    logic                way;
    logic [REG_MAX-1:0]  regd;
    logic [ADDR_MAX-1:0] addr;
    logic [DATA_MAX-1:0] data;
  } entry_t;

  function automatic entry_t empty_entry();
    entry_t e;
    e      = '0;
    e.addr = INVALID_ADDR;
    return e;
  endfunction

endpackage

// File: rtl/mshr_match.sv
// Youngest-match address comparator over the circular queue; entries are
// scanned oldest (head) to youngest so the last hit wins.
module mshr_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [ADDR_W-1:0]        addrs [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [ADDR_W-1:0]        key,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int PTR_W = $clog2(DEPTH);

  // Age-ordered scan; a later (younger) match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] pos;
    logic             m;
    hit = 1'b0;
    idx = '0;
    pos = '0;
    m   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = PTR_W'((int'(head) + i) % DEPTH);
      m   = valid[pos] && (addrs[pos] == key);
      hit = hit | m;
      idx = m ? pos : idx;
    end
  end

endmodule

// File: rtl/mshr_fifo.sv
// MSHR queue: circular buffer of load misses and dirty evictions serviced
// in order through a single memory port. Define MSHR_FWD_EN to let a load
// hitting a pending eviction complete from the queued write data.
module mshr_fifo
  import mshr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [ADDR_W-1:0]          addr_load,
  input  logic [REG_W-1:0]           regD_in,
  input  logic                       load_way_in,
  input  logic                       evict_valid,
  input  logic [ADDR_W-1:0]          addr_evict,
  input  logic [DATA_W-1:0]          evict_data,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic                       lookup_is_store,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_valid,
  output logic                       done_pulse,
  output logic [ADDR_W-1:0]          addr_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [REG_W-1:0]           regD_out,
  output logic                       load_way_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t           q [DEPTH];
  entry_t           hd;
  entry_t           load_ent;
  entry_t           evict_ent;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] evict_slot;
  logic [PTR_W-1:0] lookup_idx;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       n_enq;
  logic             retire;
  logic             mem_load_done;
  logic             load_enq;
  logic             evict_enq;
  logic             fwd;
  logic [DATA_W-1:0] fwd_data;
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_store;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic              unused_hd;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  assign hd = q[head];
  // Upper bits of the widest-case fields and the head valid flag are never consumed.
  assign unused_hd = ^{hd.valid, hd.addr, hd.data, hd.regd};

  // Flatten the entry fields the comparators need.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = q[i].valid;
      ent_store[i] = !q[i].lw;
      ent_addr[i]  = q[i].addr[ADDR_W-1:0];
    end
  end

  mshr_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lookup (
    .valid (ent_valid),
    .addrs (ent_addr),
    .head  (head),
    .key   (lookup_addr),
    .hit   (lookup_hit),
    .idx   (lookup_idx)
  );
  assign lookup_is_store = lookup_hit && ent_store[lookup_idx];

  assign retire        = (state == WAIT) && mem_valid;
  assign mem_load_done = retire && hd.lw;

`ifdef MSHR_FWD_EN
  logic [DEPTH-1:0] evict_mask;
  logic             fwd_hit;
  logic [PTR_W-1:0] fwd_idx;

  assign evict_mask = ent_valid & ent_store;

  mshr_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fwd (
    .valid (evict_mask),
    .addrs (ent_addr),
    .head  (head),
    .key   (addr_load),
    .hit   (fwd_hit),
    .idx   (fwd_idx)
  );
  // The done port is single-ported, so a memory load completion takes priority.
  assign fwd      = load_valid && fwd_hit && !mem_load_done;
  assign fwd_data = q[fwd_idx].data[DATA_W-1:0];
`else
  assign fwd      = 1'b0;
  assign fwd_data = '0;
`endif

  assign load_enq   = load_valid && !fwd;
  assign evict_enq  = evict_valid;
  assign n_enq      = 2'(load_enq) + 2'(evict_enq);
  assign evict_slot = ptr_add(tail, int'(load_enq));
  assign count_next = CNT_W'(int'(count) + int'(n_enq) - int'(retire));
  assign full       = (count >= CNT_W'(DEPTH-1));

  assign mem_req   = (state == REQ);
  assign mem_we    = !hd.lw;
  assign mem_addr  = hd.addr[ADDR_W-1:0];
  assign mem_wdata = hd.data[DATA_W-1:0];

  // Assemble the records written at the tail for this cycle's requests.
  always_comb begin
    load_ent       = empty_entry();
    load_ent.lw    = 1'b1;
    load_ent.valid = 1'b1;
    load_ent.way   = load_way_in;
    load_ent.regd  = REG_MAX'(regD_in);
    load_ent.addr  = ADDR_MAX'(addr_load);
    evict_ent       = empty_entry();
    evict_ent.valid = 1'b1;
    evict_ent.addr  = ADDR_MAX'(addr_evict);
    evict_ent.data  = DATA_MAX'(evict_data);
  end

  // Queue storage, pointers and occupancy; load lands before a same-cycle evict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= empty_entry();
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire) begin
        q[head] <= empty_entry();
        head    <= ptr_add(head, 1);
      end
      if (load_enq)  q[tail]       <= load_ent;
      if (evict_enq) q[evict_slot] <= evict_ent;
      tail  <= ptr_add(tail, int'(n_enq));
      count <= count_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: one request cycle per head entry, then wait for completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (n_enq != 2'd0) state_next = REQ;
        else               state_next = IDLE;
      end
      REQ: state_next = WAIT;
      WAIT: begin
        if (!mem_valid)               state_next = WAIT;
        else if (count_next != '0)    state_next = REQ;
        else                          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load completion report to the dcache, one cycle after the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_pulse   <= 1'b0;
      addr_out     <= INVALID_ADDR[ADDR_W-1:0];
      data_out     <= '0;
      regD_out     <= '0;
      load_way_out <= 1'b0;
    end else if (mem_load_done) begin
      done_pulse   <= 1'b1;
      addr_out     <= hd.addr[ADDR_W-1:0];
      data_out     <= mem_rdata;
      regD_out     <= hd.regd[REG_W-1:0];
      load_way_out <= hd.way;
    end else if (fwd) begin
      done_pulse   <= 1'b1;
      addr_out     <= addr_load;
      data_out     <= fwd_data;
      regD_out     <= regD_in;
      load_way_out <= load_way_in;
    end else begin
      done_pulse   <= 1'b0;
      addr_out     <= INVALID_ADDR[ADDR_W-1:0];
      data_out     <= '0;
      regD_out     <= '0;
      load_way_out <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && (load_enq || evict_enq) && full)
      $fatal(1, "mshr_fifo: enqueue while full (count=%0d)", count);
  end
`endif

endmodule

// File: tb/tb_mshr_fifo.sv
// Scoreboard bench for mshr_fifo (DEPTH=8): stimulus pushes expected memory
// requests and load completions; a monitor pops and compares them.
module tb_mshr_fifo;

  logic        clk, rst;
  logic        load_valid, load_way_in, evict_valid;
  logic [31:0] addr_load, addr_evict, evict_data, lookup_addr;
  logic [4:0]  regD_in;
  logic        lookup_hit, lookup_is_store, full;
  logic [3:0]  count;
  logic        mem_req, mem_we, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        done_pulse, load_way_out;
  logic [31:0] addr_out, data_out;
  logic [4:0]  regD_out;

  mshr_fifo #(.DEPTH(8), .ADDR_W(32), .DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .addr_load(addr_load), .regD_in(regD_in), .load_way_in(load_way_in),
    .evict_valid(evict_valid), .addr_evict(addr_evict), .evict_data(evict_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_is_store(lookup_is_store),
    .full(full), .count(count),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .done_pulse(done_pulse), .addr_out(addr_out), .data_out(data_out),
    .regD_out(regD_out), .load_way_out(load_way_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mreq_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [4:0] regd; logic way; } done_t;

  mreq_t exp_mem[$];
  done_t exp_done[$];
  int checks = 0;
  int errors = 0;
  int lat = 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'h0000_CAFE ^ (a - 32'h0000_0100);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input logic [31:0] a, input logic [4:0] rd, input logic wy);
    exp_mem.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
    exp_done.push_back('{addr: a, data: mem_data(a), regd: rd, way: wy});
  endtask

  task automatic push_evict(input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back('{we: 1'b1, addr: a, wdata: d});
  endtask

  task automatic drive(input logic lv, input logic [31:0] la, input logic [4:0] rd, input logic wy,
                       input logic ev, input logic [31:0] ea, input logic [31:0] ed);
    load_valid = lv; addr_load = la; regD_in = rd; load_way_in = wy;
    evict_valid = ev; addr_evict = ea; evict_data = ed;
    tick();
    load_valid = 1'b0; evict_valid = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] a, input logic hit, input logic st);
    lookup_addr = a;
    #1;
    chk({name, "_hit"}, 64'(lookup_hit), 64'(hit));
    chk({name, "_is_store"}, 64'(lookup_is_store), 64'(st));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_done.size() != 0 || count != 4'd0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drain_mem"}, 64'(exp_mem.size()), 64'd0);
    chk({name, "_drain_done"}, 64'(exp_done.size()), 64'd0);
    chk({name, "_drain_count"}, 64'(count), 64'd0);
  endtask

  // Memory model: answers each request lat cycles later with mem_data(addr).
  initial begin
    logic        pending;
    int          cnt;
    logic [31:0] a;
    pending = 1'b0; cnt = 0; a = '0;
    mem_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        mem_valid = 1'b0;
        mem_rdata = '0;
      end
      if (mem_req) begin
        pending = 1'b1; cnt = lat; a = mem_addr;
      end else if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem_data(a);
          pending   = 1'b0;
        end
      end
    end
  end

  // Monitor: every request and completion the DUT presents must be expected.
  initial begin
    mreq_t m;
    done_t d;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        chk("mem_req_expected", 64'(exp_mem.size() > 0), 64'd1);
        if (exp_mem.size() > 0) begin
          m = exp_mem.pop_front();
          chk("mem_we", 64'(mem_we), 64'(m.we));
          chk("mem_addr", 64'(mem_addr), 64'(m.addr));
          if (m.we) chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
        end
      end
      if (done_pulse) begin
        chk("done_expected", 64'(exp_done.size() > 0), 64'd1);
        if (exp_done.size() > 0) begin
          d = exp_done.pop_front();
          chk("done_addr", 64'(addr_out), 64'(d.addr));
          chk("done_data", 64'(data_out), 64'(d.data));
          chk("done_regd", 64'(regD_out), 64'(d.regd));
          chk("done_way", 64'(load_way_out), 64'(d.way));
        end
      end else begin
        chk("idle_addr_out", 64'(addr_out), 64'hDEAD_BEEF);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load_valid = 1'b0; evict_valid = 1'b0; load_way_in = 1'b0;
    addr_load = '0; addr_evict = '0; evict_data = '0; regD_in = '0;
    lookup_addr = 32'hDEAD_BEEF;
    repeat (2) tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_done", 64'(done_pulse), 64'd0);
    chk("rst_addr_out", 64'(addr_out), 64'hDEAD_BEEF);
    look("rst_lookup", 32'hDEAD_BEEF, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Single load, memory answers after three cycles.
    lat = 3;
    exp_mem.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_done.push_back('{addr: 32'h100, data: 32'h0000_CAFE, regd: 5'd5, way: 1'b1});
    drive(1'b1, 32'h100, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("t1_count", 64'(count), 64'd1);
    look("t1_lookup", 32'h100, 1'b1, 1'b0);
    drain("t1", 60);

    // Load and evict in one cycle: read first, then write, one completion.
    lat = 2;
    push_load(32'h200, 5'd7, 1'b0);
    push_evict(32'h300, 32'h1234_5678);
    drive(1'b1, 32'h200, 5'd7, 1'b0, 1'b1, 32'h300, 32'h1234_5678);
    chk("t2_count", 64'(count), 64'd2);
    look("t2_lookup_evict", 32'h300, 1'b1, 1'b1);
    look("t2_lookup_load", 32'h200, 1'b1, 1'b0);
    look("t2_lookup_miss", 32'h250, 1'b0, 1'b0);
    drain("t2", 60);

    // Same address in one cycle: the evict is the younger entry.
    push_load(32'h700, 5'd2, 1'b1);
    push_evict(32'h700, 32'hABCD_0000);
    drive(1'b1, 32'h700, 5'd2, 1'b1, 1'b1, 32'h700, 32'hABCD_0000);
    chk("t3_count", 64'(count), 64'd2);
    look("t3_lookup", 32'h700, 1'b1, 1'b1);
    drain("t3", 60);

    // Fill to DEPTH-1 while the first request is held outstanding.
    lat = 40;
    for (int i = 0; i < 7; i++) begin
      push_load(32'h1000 + 32'(i * 16), 5'(i), 1'(i));
      drive(1'b1, 32'h1000 + 32'(i * 16), 5'(i), 1'(i), 1'b0, 32'h0, 32'h0);
      chk("t4_count", 64'(count), 64'(i + 1));
      chk("t4_full", 64'(full), 64'(i + 1 >= 7));
    end
    lat = 1;
    drain("t4", 400);

    // Sustained mixed traffic wraps the pointers past the last entry.
    for (int i = 0; i < 12; i++) begin
      for (int g = 0; g < 50 && full; g++) tick();
      chk("t5_not_full", 64'(full), 64'd0);
      if (i % 3 == 2) begin
        push_evict(32'h2000 + 32'(i * 4), 32'hE000_0000 + 32'(i));
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h2000 + 32'(i * 4), 32'hE000_0000 + 32'(i));
      end else begin
        push_load(32'h2000 + 32'(i * 4), 5'(i), 1'(i));
        drive(1'b1, 32'h2000 + 32'(i * 4), 5'(i), 1'(i), 1'b0, 32'h0, 32'h0);
      end
    end
    drain("t5", 300);

    // Load to an address with a pending eviction.
    lat = 6;
    push_evict(32'h400, 32'h55);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h400, 32'h55);
    chk("t6_evict_count", 64'(count), 64'd1);
`ifdef MSHR_FWD_EN
    exp_done.push_back('{addr: 32'h400, data: 32'h55, regd: 5'd3, way: 1'b0});
    drive(1'b1, 32'h400, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_fwd_count", 64'(count), 64'd1);
    chk("t6_fwd_pulse", 64'(done_pulse), 64'd1);
    chk("t6_fwd_data", 64'(data_out), 64'h55);
`else
    push_load(32'h400, 5'd3, 1'b0);
    drive(1'b1, 32'h400, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_nofwd_count", 64'(count), 64'd2);
`endif
    drain("t6", 80);

    // Reset while waiting on memory; the late response must be ignored.
    lat = 8;
    exp_mem.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0});
    drive(1'b1, 32'h3000, 5'd1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h3004, 5'd2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h3008, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t7_count_before", 64'(count), 64'd3);
    tick();
    rst = 1'b1;
    #1;
    chk("t7_rst_count", 64'(count), 64'd0);
    chk("t7_rst_addr_out", 64'(addr_out), 64'hDEAD_BEEF);
    chk("t7_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t7_rst_full", 64'(full), 64'd0);
    tick();
    rst = 1'b0;
    look("t7_lookup", 32'h3004, 1'b0, 1'b0);
    repeat (12) tick();
    chk("t7_count_after", 64'(count), 64'd0);
    chk("t7_exp_mem", 64'(exp_mem.size()), 64'd0);

    // Normal service resumes after the abandoned request.
    lat = 2;
    push_load(32'h100, 5'd9, 1'b0);
    drive(1'b1, 32'h100, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0);
    drain("t8", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mshr_fifo.md
MSHR_FIFO -- requirements
Module: mshr_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count; legal range 2..16.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width.
REQ-004 Parameter REG_W, default 5, SHALL set the destination-register tag width.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-007 Ports load_valid/addr_load/regD_in/load_way_in, inputs, 1/ADDR_W/REG_W/1 bits, SHALL carry the load-miss request.
REQ-008 Ports evict_valid/addr_evict/evict_data, inputs, 1/ADDR_W/DATA_W bits, SHALL carry the dirty-eviction write request.
REQ-009 Port lookup_addr, input, ADDR_W bits, SHALL carry the address to check against pending entries.
REQ-010 Ports lookup_hit/lookup_is_store, outputs, 1 bit each, SHALL report combinationally a match on any valid entry, and whether the youngest match is an evict.
REQ-011 Ports full, output, 1 bit (combinational), and count, output, $clog2(DEPTH+1) bits (registered), SHALL report occupancy.
REQ-012 Ports mem_req/mem_we/mem_addr/mem_wdata, outputs, 1/1/ADDR_W/DATA_W bits, SHALL drive the memory port from the head entry.
REQ-013 Ports mem_rdata/mem_valid, inputs, DATA_W/1 bits, SHALL return memory completion.
REQ-014 Ports done_pulse/addr_out/data_out/regD_out/load_way_out, registered outputs, 1/ADDR_W/DATA_W/REG_W/1 bits, SHALL report load completion to the dcache.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries (lw, valid, way, regD, addr, data) with head/tail pointers wrapping modulo DEPTH.
REQ-016 Same-cycle load and evict SHALL enqueue load first, then evict, consuming two entries.
REQ-017 full SHALL equal (count >= DEPTH-1).
REQ-018 FSM SHALL be IDLE (empty), REQ (mem_req=1 for exactly one cycle), WAIT (await mem_valid).
REQ-019 Transitions: IDLE->REQ on any enqueue; REQ->WAIT always; WAIT->REQ on mem_valid if entries remain or arrive that cycle; WAIT->IDLE on mem_valid if the queue becomes empty.
REQ-020 mem_we SHALL equal !lw of the head entry; mem_addr and mem_wdata SHALL equal the head addr and data.
REQ-021 On mem_valid with a head lw entry, done_pulse SHALL be 1 in the next cycle, with addr_out=head addr, data_out=mem_rdata, regD_out and load_way_out from the head; on a head evict, no pulse.
REQ-022 Retire (head advance) and enqueue in the same cycle SHALL both take effect; count = count - 1 + enqueued.
REQ-023 Empty entries and idle addr_out SHALL read ADDR_W'hDEAD_BEEF (truncated or zero-extended); done_pulse SHALL otherwise be 0.
REQ-024 Enqueue while full SHALL trigger a simulation $fatal; RTL behaviour is then undefined.

Reset
REQ-025 rst SHALL clear all entries (valid=0, addr=DEAD_BEEF, data/regD/way/lw=0), pointers, and count, set state=IDLE, done_pulse=0, addr_out=DEAD_BEEF, and other outputs to 0.
REQ-026 Reset asserted in WAIT SHALL abandon the outstanding request; a late mem_valid after release in IDLE SHALL be ignored.

Configuration
REQ-027 Macro MSHR_FWD_EN defined: a load whose addr_load matches a valid evict entry (youngest match) SHALL NOT enqueue and SHALL complete with done_pulse next cycle, data_out = that evict's data.
REQ-028 With MSHR_FWD_EN: if a memory lw completion also occurs that cycle, memory wins and the load SHALL enqueue normally; a same-cycle incoming evict SHALL NOT forward.
REQ-029 Without MSHR_FWD_EN, every load SHALL enqueue and access memory.

Structure
REQ-030 Package mshr_pkg SHALL hold the state enum (IDLE/REQ/WAIT), the entry struct typedef, and the invalid-address constant.
REQ-031 Sub-module mshr_match SHALL implement the parametrised youngest-match address comparator shared by lookup and forwarding.

Verification
REQ-032 Single load 0x100, mem_valid after 3 cycles with rdata 0xCAFE -> done_pulse one cycle later, data_out=0xCAFE, state back to IDLE.
REQ-033 Load 0x200 with evict 0x300 same cycle -> memory order read 0x200 then write 0x300; exactly one done_pulse.
REQ-034 DEPTH=8, 7 enqueues -> full=1 at count 7; sustained traffic wraps tail past entry 7 with FIFO order kept.
REQ-035 MSHR_FWD_EN, evict 0x400 data 0x55 pending, load 0x400 -> done_pulse next cycle, data_out=0x55, count unchanged.
REQ-036 Assert rst in WAIT with 3 entries -> count=0, IDLE, addr_out=DEAD_BEEF; stray mem_valid -> no pulse.
